sr_chain_driver: RTL and testbench

//  Output stage after the 64 PWM channel generators. Snapshots the 64-bit channel vector
//  and shifts it out on 8 parallel serial lanes, one per external 8-bit latch-type shift register.

---
 rtl/sr_pkg.sv | 19 +
 rtl/sr_chain_driver_tick.sv | 30 +++
 rtl/sr_chain_driver.sv | 102 ++++++++++
 tb/tb_sr_chain_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the PWM output shift-register chain driver.
package sr_pkg;

    localparam int LANES_DEF = 8;
    localparam int BPL_DEF   = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_LATCH    = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    // A counter for n states never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_chain_driver_tick.sv
// Half-period divider: counts clk cycles within a state, ticks on the last one.
module sr_tick_gen
    import sr_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/sr_chain_driver.sv
// Snapshots the channel vector and shifts it MSB-first into LANES external
// latch-type shift registers, then strobes latch so all outputs update at once.
module sr_chain_driver
    import sr_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int BPL     = BPL_DEF,
    parameter int CLK_DIV = 4,
    parameter int LATCH_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LANES*BPL-1:0]   frame_in,
    output logic                   clock,
    output logic                   latch,
    output logic [LANES-1:0]       data,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int BW = cnt_w(BPL);
    localparam int LW = cnt_w(LATCH_W);
    localparam logic [BW-1:0] BLAST = BW'(BPL - 1);
    localparam logic [LW-1:0] LLAST = LW'(LATCH_W - 1);

    logic [2:0]                  state;
    logic [2:0]                  nxt;
    logic                        tick;
    logic [BW-1:0]               bcnt;
    logic [LW-1:0]               lcnt;
    logic [LANES-1:0][BPL-1:0]   sh;
    logic [LANES-1:0][BPL-1:0]   src;

    // Divider restarts on every state change so each phase is CLK_DIV long.
    sr_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (nxt != state),
        .tick  (tick)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:     if (enable) nxt = S_LOAD;
            S_LOAD:     nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (tick) nxt = S_SHIFT_HI;
            S_SHIFT_HI: if (tick) nxt = (bcnt == BLAST) ? S_LATCH : S_SHIFT_LO;
            S_LATCH:    if (lcnt == LLAST) nxt = S_GAP;
            S_GAP:      nxt = enable ? S_LOAD : S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    // First bit comes straight from frame_in so LOAD costs only one cycle.
    assign src = (state == S_LOAD) ? frame_in : sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bcnt       <= '0;
            lcnt       <= '0;
            sh         <= '0;
            data       <= '0;
            clock      <= 1'b0;
            latch      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            clock      <= (nxt == S_SHIFT_HI);
            latch      <= (nxt == S_LATCH);
            busy       <= (nxt != S_IDLE);
            frame_done <= (nxt == S_GAP);

            if (state == S_SHIFT_HI && tick) begin
                bcnt <= (bcnt == BLAST) ? '0 : bcnt + 1'b1;
            end else if (state == S_IDLE || state == S_LOAD) begin
                bcnt <= '0;
            end

            if (state == S_LATCH) begin
                lcnt <= lcnt + 1'b1;
            end else begin
                lcnt <= '0;
            end

            if (nxt == S_SHIFT_LO && state != S_SHIFT_LO) begin
                for (int l = 0; l < LANES; l++) begin
                    data[l] <= src[l][BPL-1];
                    sh[l]   <= src[l] << 1;
                end
            end else if (nxt == S_IDLE) begin
                data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sr_chain_driver.sv
// Scoreboard bench: two driver configurations run side by side against a frame-position model.
module tb_sr_chain_driver;

    localparam int BPL   = 8;
    localparam int LANES = 8;
    localparam int DV [2] = '{4, 1};
    localparam int LWV[2] = '{2, 1};

    function automatic int flen(input int u);
        return 2 + 2 * DV[u] * BPL + LWV[u];
    endfunction

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [63:0]       frame_in = '0;
    logic [1:0]        clock, latch, busy, fdone;
    logic [1:0][7:0]   data;

    always #5 clk = ~clk;

    sr_chain_driver u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
        .clock(clock[0]), .latch(latch[0]), .data(data[0]),
        .busy(busy[0]), .frame_done(fdone[0])
    );

    sr_chain_driver #(.CLK_DIV(1), .LATCH_W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
        .clock(clock[1]), .latch(latch[1]), .data(data[1]),
        .busy(busy[1]), .frame_done(fdone[1])
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int u,
                       input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s dut%0d: got %h expected %h at %0t",
                         nm, u, act, exp, $time);
        end
    endtask

    // Reference: position within the current frame (0 = idle, 1 = load cycle).
    int          mpos[2];
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpos[0] <= 0;
            mpos[1] <= 0;
            q0.delete();
            q1.delete();
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (mpos[u] == 1) begin
                    if (u == 0) q0.push_back(frame_in);
                    else        q1.push_back(frame_in);
                end
                if (mpos[u] == 0 || mpos[u] == flen(u))
                    mpos[u] <= enable ? 1 : 0;
                else
                    mpos[u] <= mpos[u] + 1;
            end
        end
    end

    logic [1:0]       pclk = '0;
    logic [1:0]       plat = '0;
    logic [1:0][7:0]  pdat = '0;
    logic [1:0][63:0] asm = '0;
    int               ns[2] = '{0, 0};

    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            int          m;
            int          p;
            logic        eclk;
            logic        elat;
            logic [63:0] exp_f;
            m    = mpos[u];
            p    = m - 2;
            eclk = (m >= 2 && p < 2 * DV[u] * BPL) ? (((p / DV[u]) % 2) == 1) : 1'b0;
            elat = (m >= 2 && p >= 2 * DV[u] * BPL && m <= flen(u) - 1);
            chk("busy", u, 64'(busy[u]), 64'(m != 0));
            chk("clock", u, 64'(clock[u]), 64'(eclk));
            chk("latch", u, 64'(latch[u]), 64'(elat));
            chk("frame_done", u, 64'(fdone[u]), 64'(m == flen(u)));
            chk("clk_latch_excl", u, 64'(clock[u] & latch[u]), 64'(1'b0));
            if (m == 0) chk("idle_data", u, 64'(data[u]), 64'(0));
            if (clock[u] && pclk[u]) chk("data_stable", u, 64'(data[u]), 64'(pdat[u]));
            if (!rst_n) ns[u] = 0;
            if (clock[u] && !pclk[u]) begin
                for (int l = 0; l < LANES; l++)
                    asm[u][l*8 +: 8] = {asm[u][l*8 +: 7], data[u][l]};
                ns[u]++;
            end
            if (latch[u] && !plat[u]) begin
                chk("shift_count", u, 64'(ns[u]), 64'(BPL));
                ns[u] = 0;
                chk("sb_depth", u, 64'(u == 0 ? q0.size() : q1.size()), 64'(1));
                if (u == 0 && q0.size() > 0) begin
                    exp_f = q0.pop_front();
                    chk("frame", u, asm[u], exp_f);
                end else if (u == 1 && q1.size() > 0) begin
                    exp_f = q1.pop_front();
                    chk("frame", u, asm[u], exp_f);
                end
            end
            pclk[u] = clock[u];
            plat[u] = latch[u];
            pdat[u] = data[u];
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy != 2'b00 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 0, 64'(k < 1000), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic run_enabled(input int cycles, input int rate);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(rate - 1, 0) == 0)
                frame_in = {$urandom, $urandom};
            else if ($urandom_range(40, 0) == 0)
                frame_in = '1;
        end
    endtask

    initial begin
        enable   = 1'b1;
        frame_in = {$urandom, $urandom};
        rst_n    = 1'b0;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame_in = 64'h0123_4567_89AB_CDEF;
        enable   = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        frame_in = '1;
        wait_idle();

        frame_in = 64'h0123_4567_89AB_CDEF;
        enable   = 1'b1;
        repeat (30) @(negedge clk);
        frame_in = '1;
        repeat (3 * 68 - 30 + $urandom_range(40, 0)) @(negedge clk);
        enable = 1'b0;
        wait_idle();

        repeat (6) begin
            enable = 1'b1;
            run_enabled($urandom_range(300, 1), 16);
            enable = 1'b0;
            wait_idle();
        end

        enable = 1'b1;
        run_enabled($urandom_range(60, 30), 8);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_enabled(150, 8);
        enable = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
